systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Operand transmitter for the PE_core mesh edge: drives the a_curr (row edge) or b_curr (column edge) inputs of an N-lane systolic array.
- Accepts K operand vectors (one N-lane vector per handshake beat) into a local buffer.
- Replays the buffer as a diagonally skewed stream: lane i is delayed i cycles, so element k reaches PE row/column i on cycle k+i.
- Outside each lane's data window it drives signed zero, so the free-running PE accumulators are not disturbed.

Parameters:
- N, 4, number of lanes (array dimension).
- DW, 8, signed operand width, matching the PE a/b width.
- DEPTH, 16, maximum vectors buffered (K_max); counters are $clog2(DEPTH+1) bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream vector valid.
- in_ready  output  1  feeder can accept a vector.
- in_data  input  N*DW  vector; lane i = in_data[i*DW +: DW], signed.
- in_last  input  1  marks the final vector of the current block.
- out_data  output  N*DW  skewed operand lanes to the array edge; lane i = out_data[i*DW +: DW].
- out_lane_valid  output  N  per-lane flag: lane i carries buffered data, not zero fill.
- busy  output  1  high in FILL or STREAM.
- done  output  1  one-cycle pulse after the last skewed element leaves.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; write count and stream counter cleared.
  - out_data = 0, out_lane_valid = 0, done = 0, busy = 0.
  - in_ready = 1 as soon as reset releases.
  - Buffer contents need not be cleared.
- States and transitions:
  - IDLE -> FILL on the first accepted beat.
  - If that first beat carries in_last, go directly IDLE -> STREAM.
  - FILL -> STREAM on an accepted beat with in_last = 1, or on the DEPTH-th accepted beat.
  - STREAM -> DONE after K+N-1 stream cycles.
  - DONE -> IDLE after exactly one cycle.
- Handshake:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - It is written to buf[wcnt], then wcnt increments.
  - in_ready = 1 in IDLE and in FILL; 0 in STREAM and DONE.
  - in_ready also drops combinationally to 0 while wcnt == DEPTH.
  - in_valid while in_ready = 0 is ignored: no capture, no state change.
  - Gaps in in_valid during FILL are legal and simply stall the fill.
- Block length: K = wcnt after the final accepted beat, 1 <= K <= DEPTH. If DEPTH beats arrive without in_last, the DEPTH-th beat is treated as last.
- Stream timing (outputs are registered):
  - Let E1 be the first rising edge after the edge that accepted the final beat.
  - After edge E(t+1), for t = 0..K+N-2, each lane i is driven as follows:
    - if 0 <= t-i < K: lane i = buf[t-i][i] and out_lane_valid[i] = 1;
    - otherwise: lane i = 0 and out_lane_valid[i] = 0.
  - Lane 0 therefore presents vector 0 in the first STREAM cycle; lane N-1 presents vector K-1 in the last stream cycle.
- After stream end:
  - On the edge following the last stream cycle, out_data = 0 and out_lane_valid = 0.
  - done = 1 for that single cycle; state = DONE.
  - Next edge: state = IDLE, wcnt = 0, done = 0.
- busy = 1 in FILL and STREAM; 0 in IDLE and DONE.
- Arithmetic: none; data is passed bit-exact, and signed values (e.g. -128) are preserved unchanged.
- Reset mid-operation (FILL or STREAM) aborts the block immediately. All outputs are zero from reset assertion; no done pulse is produced.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> out_data = 0, out_lane_valid = 0, done = 0, busy = 0; after release in_ready = 1.
- K=2, N=4: beats v0 = {1,2,3,4} (lane0..3) and v1 = {-5,6,-7,8} with in_last on v1. Required lanes per stream cycle (lanes not listed are 0 / valid 0):
  - c0: lane0 = 1.
  - c1: lane0 = -5, lane1 = 2.
  - c2: lane1 = 6, lane2 = 3.
  - c3: lane2 = -7, lane3 = 4.
  - c4: lane3 = 8.
  - Next cycle: all lanes 0, done = 1.
- K=1: single beat {7,-3,1,-128} with in_last -> 4 stream cycles; cycle j has only lane j non-zero: 7, -3, 1, -128. Then done pulse.
- Overflow: 16 beats, value v = beat index 0..15 on every lane, no in_last:
  - in_ready falls after the 16th beat, and a 17th in_valid is not captured.
  - Stream lasts 19 cycles; lane3 carries 15 in cycle 18.
- Backpressure/ignore:
  - in_valid toggling 1,0,1 during FILL captures exactly 2 beats.
  - in_valid held high during STREAM leaves wcnt and the stream unchanged.
  - in_ready = 0 through STREAM and DONE.
- Reset mid-stream: rst_n = 0 at stream cycle 2 of the K=2 case -> outputs 0 immediately, no done pulse. After release, a new K=1 block streams correctly.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for one edge of an N-lane systolic mesh: buffers K vectors,
// then replays them diagonally skewed (lane i delayed i cycles) with zero fill.
module systolic_skew_feeder #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_lane_valid,
  output logic            busy,
  output logic            done
);

  localparam int unsigned VW = N * DW;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(DEPTH + N);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]   scnt_q, scnt_d;
  logic [VW-1:0]   buf_q [DEPTH];
  logic [VW-1:0]   buf_d [DEPTH];
  logic [VW-1:0]   out_data_q, out_data_d;
  logic [N-1:0]    out_lane_valid_q, out_lane_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic [TW-1:0]   last_t;

  // Ready is combinational so a full buffer stalls upstream in the same cycle.
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_FILL)) &&
                    (wcnt_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign last_t   = TW'(wcnt_q) + TW'(N - 1);

  // State register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next state, write count and stream counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          wcnt_d = wcnt_q + CW'(1);
          scnt_d = '0;
          if (in_last || (wcnt_q == CW'(DEPTH - 1))) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_STREAM: begin
        scnt_d = scnt_q + TW'(1);
        if (scnt_q == last_t) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
        scnt_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Vector buffer: contents are don't-care until written, so no reset.
  always_comb begin
    buf_d = buf_q;
    if (accept) begin
      buf_d[AW'(wcnt_q)] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Registered outputs; scnt_q beyond the data window yields zero on every lane
  always_comb begin
    out_data_d       = '0;
    out_lane_valid_d = '0;
    done_d           = (state_q == S_STREAM) && (scnt_q == last_t);
    busy_d           = (state_d == S_FILL) || (state_d == S_STREAM);
    for (int unsigned i = 0; i < N; i++) begin
      if ((state_q == S_STREAM) && (scnt_q >= TW'(i)) &&
          ((scnt_q - TW'(i)) < TW'(wcnt_q))) begin
        out_data_d[i*DW +: DW] = buf_q[AW'(scnt_q - TW'(i))][i*DW +: DW];
        out_lane_valid_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q       <= '0;
      out_lane_valid_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      out_data_q       <= out_data_d;
      out_lane_valid_q <= out_lane_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_lane_valid = out_lane_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a cycle table for the K=2 case,
// then hand sequences and random blocks checked against a skew model.
module tb_systolic_skew_feeder;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned VW    = N * DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic [VW-1:0] out_data;
  logic [N-1:0]  out_lane_valid;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] tb_vec [DEPTH];

  systolic_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [VW-1:0] data;
    logic          last;
    logic [VW-1:0] e_data;
    logic [N-1:0]  e_lv;
    logic          e_done;
    logic          e_busy;
    logic          e_ready;
  } row_t;

  row_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Element k of the block reaches lane i at stream cycle k+i.
  function automatic logic [VW-1:0] model_data(input int t, input int k);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if ((t - i) >= 0 && (t - i) < k) r[i*DW +: DW] = tb_vec[t-i][i*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] model_lv(input int t, input int k);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if ((t - i) >= 0 && (t - i) < k) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Load k beats from tb_vec, then check every stream cycle, the done pulse and return to idle.
  task automatic run_block(input int k, input bit use_last, input bit gaps, input bit hold);
    for (int b = 0; b < k; b++) begin
      if (gaps && b > 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
      end
      chk($sformatf("ready_fill_b%0d", b), 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = tb_vec[b];
      in_last  = use_last && (b == k - 1);
      @(posedge clk); #1;
    end
    if (hold) begin
      in_valid = 1'b1;
      in_data  = '1;
      in_last  = 1'b1;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    chk("ready_after_last", 64'(in_ready), 64'(0));
    chk("busy_after_last", 64'(busy), 64'(1));
    for (int t = 0; t < k + N - 1; t++) begin
      @(posedge clk); #1;
      chk($sformatf("data_k%0d_t%0d", k, t), 64'(out_data), 64'(model_data(t, k)));
      chk($sformatf("lv_k%0d_t%0d", k, t), 64'(out_lane_valid), 64'(model_lv(t, k)));
      chk($sformatf("done_k%0d_t%0d", k, t), 64'(done), 64'(0));
      chk($sformatf("ready_k%0d_t%0d", k, t), 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    chk("end_data", 64'(out_data), 64'(0));
    chk("end_lv", 64'(out_lane_valid), 64'(0));
    chk("end_done", 64'(done), 64'(1));
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_ready", 64'(in_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    // K=2 cycle table: {vld, data, last, e_data, e_lv, e_done, e_busy, e_ready}
    tbl[0] = '{1'b1, 32'h04030201, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 32'h08F906FB, 1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h00000000, 1'b0, 32'h00000001, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'hDEADBEEF, 1'b1, 32'h000002FB, 4'b0011, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h00000000, 1'b0, 32'h00030600, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h00000000, 1'b0, 32'h04F90000, 4'b1100, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'h00000000, 1'b0, 32'h08000000, 4'b1000, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #12;
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_lv", 64'(out_lane_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(in_ready), 64'(1));

    for (int r = 0; r < 9; r++) begin
      in_valid = tbl[r].vld;
      in_data  = tbl[r].data;
      in_last  = tbl[r].last;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_data", r), 64'(out_data), 64'(tbl[r].e_data));
      chk($sformatf("tbl%0d_lv", r), 64'(out_lane_valid), 64'(tbl[r].e_lv));
      chk($sformatf("tbl%0d_done", r), 64'(done), 64'(tbl[r].e_done));
      chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].e_ready));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // K=1, signed extremes preserved
    tb_vec[0] = {8'h80, 8'h01, 8'hFD, 8'h07};
    run_block(1, 1'b1, 1'b0, 1'b0);

    // Overflow: 16 beats without last; a held 17th beat must be ignored
    for (int b = 0; b < DEPTH; b++) tb_vec[b] = {N{8'(b)}};
    run_block(DEPTH, 1'b0, 1'b0, 1'b1);

    // Gapped fill (valid 1,0,1) with valid held through the stream
    tb_vec[0] = $urandom;
    tb_vec[1] = $urandom;
    run_block(2, 1'b1, 1'b1, 1'b1);

    // Reset during stream cycle 2 of the K=2 case
    in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h08F906FB; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_pre_lv", 64'(out_lane_valid), 64'(4'b0110));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 64'(out_data), 64'(0));
    chk("mid_rst_lv", 64'(out_lane_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_rst_nodone%0d", c), 64'(done), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(in_ready), 64'(1));
    chk("mid_rel_done", 64'(done), 64'(0));
    tb_vec[0] = {8'h80, 8'h01, 8'hFD, 8'h07};
    run_block(1, 1'b1, 1'b0, 1'b0);

    // Random blocks
    for (int n = 0; n < 8; n++) begin
      int  k;
      bit  ul;
      k  = int'($urandom_range(1, DEPTH));
      ul = (k < int'(DEPTH)) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int b = 0; b < k; b++) tb_vec[b] = $urandom;
      run_block(k, ul, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
